// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one DMI target between two requesters with one transaction in flight.
// Optional REQ watchdog (TIMEOUT_CYCLES, timeout_err_o) is enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arbiter #(
   parameter bit          RR_EN  = 1'b1,
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32
`ifdef DMI_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_valid_i,
   input  logic              m0_write_en_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ready_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_valid_i,
   input  logic              m1_write_en_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ready_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              s_valid_o,
   output logic              s_write_en_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic              s_ready_i,
   input  logic [DATA_W-1:0] s_rdata_i,
   output logic              busy_o,
   output logic              timeout_err_o
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_e;

   state_e            state_q, state_d;
   logic              gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
   logic              s_valid_q, s_valid_d, s_we_q, s_we_d;
   logic [ADDR_W-1:0] s_addr_q, s_addr_d;
   logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
   logic              m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic              busy_q, busy_d;
   logic              any_valid, pick, timeout_hit;
   logic [DATA_W-1:0] rsp_data;

   assign any_valid = m0_valid_i | m1_valid_i;

`ifdef DMI_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = 32;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   // The limit is hit in the REQ cycle that would be the TIMEOUT_CYCLES-th one.
   assign timeout_hit   = (state_q == ST_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err_o = err_q;
`else
   assign timeout_hit   = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

   // Winner when more than one requester is pending.
   always_comb begin
      pick = 1'b0;
      if (RR_EN) pick = (m0_valid_i && m1_valid_i) ? rr_ptr_q : m1_valid_i;
      else       pick = !m0_valid_i;
   end

   // Writes return zero; a watchdog expiry returns a poison pattern unless the target answered.
   always_comb begin
      rsp_data = s_we_q ? '0 : s_rdata_i;
      if (!s_ready_i && timeout_hit) rsp_data = DATA_W'(32'hDEAD_BEEF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_valid) state_d = ST_REQ;
         ST_REQ:  if (s_ready_i || timeout_hit) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      s_valid_d  = s_valid_q;
      s_we_d     = s_we_q;
      s_addr_d   = s_addr_q;
      s_wdata_d  = s_wdata_q;
      m0_ready_d = 1'b0;
      m1_ready_d = 1'b0;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      busy_d     = (state_d != ST_IDLE);
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               gnt_d     = pick;
               s_valid_d = 1'b1;
               s_we_d    = pick ? m1_write_en_i : m0_write_en_i;
               s_addr_d  = pick ? m1_addr_i     : m0_addr_i;
               s_wdata_d = pick ? m1_wdata_i    : m0_wdata_i;
`ifdef DMI_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         ST_REQ: begin
`ifdef DMI_ARB_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_hit && !s_ready_i) err_d = 1'b1;
`endif
            // Response registers load here so ready/rdata are visible during RESP.
            if (s_ready_i || timeout_hit) begin
               s_valid_d = 1'b0;
               if (gnt_q) begin
                  m1_ready_d = 1'b1;
                  m1_rdata_d = rsp_data;
               end else begin
                  m0_ready_d = 1'b1;
                  m0_rdata_d = rsp_data;
               end
            end
         end
         ST_RESP: rr_ptr_d = ~gnt_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q      <= 1'b0;
         rr_ptr_q   <= 1'b0;
         s_valid_q  <= 1'b0;
         s_we_q     <= 1'b0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         m0_ready_q <= 1'b0;
         m1_ready_q <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         busy_q     <= 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         s_valid_q  <= s_valid_d;
         s_we_q     <= s_we_d;
         s_addr_q   <= s_addr_d;
         s_wdata_q  <= s_wdata_d;
         m0_ready_q <= m0_ready_d;
         m1_ready_q <= m1_ready_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         busy_q     <= busy_d;
`ifdef DMI_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign s_valid_o    = s_valid_q;
   assign s_write_en_o = s_we_q;
   assign s_addr_o     = s_addr_q;
   assign s_wdata_o    = s_wdata_q;
   assign m0_ready_o   = m0_ready_q;
   assign m0_rdata_o   = m0_rdata_q;
   assign m1_ready_o   = m1_ready_q;
   assign m1_rdata_o   = m1_rdata_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Timeout scenario is exercised only when DMI_ARB_TIMEOUT_EN is defined.
module tb_dmi_arbiter;

   localparam logic [6:0] DMCONTROL = 7'h10;
   localparam logic [6:0] DATA0     = 7'h04;

   typedef struct {
      bit          req;
      bit          we;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      int          svc;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        m_valid [2][2];
   logic        m_we    [2][2];
   logic [6:0]  m_addr  [2][2];
   logic [31:0] m_wdata [2][2];
   logic        m_ready [2][2];
   logic [31:0] m_rdata [2][2];
   logic        s_valid [2];
   logic        s_we    [2];
   logic [6:0]  s_addr  [2];
   logic [31:0] s_wdata [2];
   logic        s_ready [2];
   logic [31:0] s_rdata [2];
   logic        busy    [2];
   logic        terr    [2];

   int          total = 0;
   int          bad   = 0;
   txn_t        sb   [$];
   txn_t        pend [$];
   logic [31:0] hold [2][2];
   int          tgt_delay;
   bit          tgt_never;
   logic [31:0] tgt_rdata;

   dmi_arbiter #(
      .RR_EN(1'b1)
`ifdef DMI_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) u_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_valid_i(m_valid[0][0]), .m0_write_en_i(m_we[0][0]), .m0_addr_i(m_addr[0][0]),
      .m0_wdata_i(m_wdata[0][0]), .m0_ready_o(m_ready[0][0]), .m0_rdata_o(m_rdata[0][0]),
      .m1_valid_i(m_valid[0][1]), .m1_write_en_i(m_we[0][1]), .m1_addr_i(m_addr[0][1]),
      .m1_wdata_i(m_wdata[0][1]), .m1_ready_o(m_ready[0][1]), .m1_rdata_o(m_rdata[0][1]),
      .s_valid_o(s_valid[0]), .s_write_en_o(s_we[0]), .s_addr_o(s_addr[0]),
      .s_wdata_o(s_wdata[0]), .s_ready_i(s_ready[0]), .s_rdata_i(s_rdata[0]),
      .busy_o(busy[0]), .timeout_err_o(terr[0])
   );

   dmi_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_valid_i(m_valid[1][0]), .m0_write_en_i(m_we[1][0]), .m0_addr_i(m_addr[1][0]),
      .m0_wdata_i(m_wdata[1][0]), .m0_ready_o(m_ready[1][0]), .m0_rdata_o(m_rdata[1][0]),
      .m1_valid_i(m_valid[1][1]), .m1_write_en_i(m_we[1][1]), .m1_addr_i(m_addr[1][1]),
      .m1_wdata_i(m_wdata[1][1]), .m1_ready_o(m_ready[1][1]), .m1_rdata_o(m_rdata[1][1]),
      .s_valid_o(s_valid[1]), .s_write_en_o(s_we[1]), .s_addr_o(s_addr[1]),
      .s_wdata_o(s_wdata[1]), .s_ready_i(s_ready[1]), .s_rdata_i(s_rdata[1]),
      .busy_o(busy[1]), .timeout_err_o(terr[1])
   );

   function automatic int front_of(input int r);
      for (int k = 0; k < pend.size(); k++)
         if (pend[k].req == 1'(r)) return k;
      return -1;
   endfunction

   // Queue a transaction in expected grant order.
   task automatic add(input bit r, input bit we, input logic [6:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int lat, input int svc);
      txn_t t;
      t.req = r; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.lat = lat; t.svc = svc;
      sb.push_back(t);
      pend.push_back(t);
   endtask

   // Drive requesters and target of instance i until the scoreboard drains.
   task automatic run(input int i, input int budget);
      int   n, svc, tcnt, idx;
      int   start [2];
      bit   loaded [2];
      txn_t e;
      n = 0; svc = 0; tcnt = 0;
      for (int r = 0; r < 2; r++) begin start[r] = 0; loaded[r] = 1'b0; end
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
         for (int r = 0; r < 2; r++) begin
            total++;
            if (m_ready[i][r] === 1'b1) begin
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL extra_ready inst=%0d req=%0d got=1 want=0", i, r);
               end else begin
                  e = sb.pop_front();
                  if (e.req !== 1'(r) || m_rdata[i][r] !== e.rdata) begin
                     bad++;
                     $display("FAIL resp inst=%0d got req=%0d rdata=%h want req=%0d rdata=%h",
                              i, r, m_rdata[i][r], e.req, e.rdata);
                  end
                  if (e.lat != 0) begin
                     total++;
                     if (cyc - start[r] != e.lat) begin
                        bad++;
                        $display("FAIL latency inst=%0d got=%0d want=%0d", i, cyc - start[r], e.lat);
                     end
                  end
                  if (e.svc != 0) begin
                     total++;
                     if (svc != e.svc) begin
                        bad++;
                        $display("FAIL s_valid_cycles inst=%0d got=%0d want=%0d", i, svc, e.svc);
                     end
                  end
                  hold[i][r] = e.rdata;
               end
               idx = front_of(r);
               if (idx >= 0) pend.delete(idx);
               loaded[r] = 1'b0;
               svc = 0;
            end else if (m_rdata[i][r] !== hold[i][r]) begin
               bad++;
               $display("FAIL rdata_hold inst=%0d req=%0d got=%h want=%h", i, r, m_rdata[i][r], hold[i][r]);
            end
         end
         if (s_valid[i] === 1'b1) begin
            if (sb.size() > 0) begin
               total++;
               if ({s_we[i], s_addr[i], s_wdata[i]} !== {sb[0].we, sb[0].addr, sb[0].wdata}) begin
                  bad++;
                  $display("FAIL s_fields inst=%0d got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                           i, s_we[i], s_addr[i], s_wdata[i], sb[0].we, sb[0].addr, sb[0].wdata);
               end
            end
            svc++;
            tcnt++;
            s_ready[i] = !tgt_never && (tcnt >= tgt_delay);
         end else begin
            tcnt = 0;
            s_ready[i] = 1'b0;
         end
         s_rdata[i] = tgt_rdata;
         for (int r = 0; r < 2; r++) begin
            if (!loaded[r]) begin
               idx = front_of(r);
               if (idx >= 0) begin
                  m_valid[i][r] = 1'b1;
                  m_we[i][r]    = pend[idx].we;
                  m_addr[i][r]  = pend[idx].addr;
                  m_wdata[i][r] = pend[idx].wdata;
                  start[r]      = cyc;
                  loaded[r]     = 1'b1;
               end else begin
                  m_valid[i][r] = 1'b0;
               end
            end
         end
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL budget inst=%0d pending=%0d want=0", i, sb.size());
      end
      for (int r = 0; r < 2; r++) m_valid[i][r] = 1'b0;
      s_ready[i] = 1'b0;
      sb.delete();
      pend.delete();
      tgt_never = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy[i] !== 1'b0) begin
         bad++;
         $display("FAIL idle_busy inst=%0d got=%b want=0", i, busy[i]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({s_valid[i], s_we[i], s_addr[i], s_wdata[i], m_ready[i][0], m_ready[i][1],
              m_rdata[i][0], m_rdata[i][1], busy[i], terr[i]} !== '0) begin
            bad++;
            $display("FAIL reset_outputs inst=%0d got sv=%b we=%b addr=%h wd=%h rdy=%b%b rd0=%h rd1=%h busy=%b terr=%b want all 0",
                     i, s_valid[i], s_we[i], s_addr[i], s_wdata[i], m_ready[i][0], m_ready[i][1],
                     m_rdata[i][0], m_rdata[i][1], busy[i], terr[i]);
         end
         hold[i][0] = '0;
         hold[i][1] = '0;
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_contention();
      tgt_delay = 1; tgt_rdata = 32'h5555_AAAA;
      add(1'b0, 1'b1, 7'h20, 32'h1111_0000, '0, 0, 1);
      add(1'b1, 1'b1, 7'h21, 32'h2222_0001, '0, 0, 1);
      add(1'b0, 1'b1, 7'h22, 32'h3333_0002, '0, 0, 1);
      add(1'b1, 1'b1, 7'h23, 32'h4444_0003, '0, 0, 1);
      run(0, 60);
   endtask

   task automatic test_single_read();
      tgt_delay = 2; tgt_rdata = 32'h0000_0001;
      add(1'b0, 1'b0, DMCONTROL, 32'h0, 32'h0000_0001, 3, 2);
      run(0, 30);
   endtask

   task automatic test_write();
      tgt_delay = 1; tgt_rdata = 32'h1234_5678;
      add(1'b1, 1'b1, DATA0, 32'hCAFE_F00D, 32'h0, 2, 1);
      run(0, 30);
   endtask

   // rr_ptr points at m1 after an m0-only transfer, so contention now starts with m1.
   task automatic test_rr_ptr();
      tgt_delay = 1; tgt_rdata = 32'h0F0F_0000;
      add(1'b0, 1'b0, 7'h30, 32'h0, 32'h0F0F_0000, 0, 0);
      run(0, 30);
      tgt_rdata = 32'h0F0F_0001;
      add(1'b1, 1'b0, 7'h31, 32'h0, 32'h0F0F_0001, 0, 1);
      add(1'b0, 1'b0, 7'h32, 32'h0, 32'h0F0F_0001, 0, 1);
      add(1'b1, 1'b0, 7'h33, 32'h0, 32'h0F0F_0001, 0, 1);
      add(1'b0, 1'b0, 7'h34, 32'h0, 32'h0F0F_0001, 0, 1);
      run(0, 60);
   endtask

   task automatic test_fixed_priority();
      tgt_delay = 2; tgt_rdata = 32'hBEEF_0000;
      add(1'b0, 1'b1, 7'h40, 32'hA000_0000, '0, 0, 2);
      add(1'b0, 1'b1, 7'h41, 32'hA000_0001, '0, 0, 2);
      add(1'b0, 1'b1, 7'h42, 32'hA000_0002, '0, 0, 2);
      add(1'b1, 1'b1, 7'h43, 32'hB000_0003, '0, 0, 2);
      run(1, 80);
   endtask

   task automatic test_limit_edge();
      tgt_delay = 8; tgt_rdata = 32'h7777_0008;
      add(1'b0, 1'b0, 7'h11, 32'h0, 32'h7777_0008, 0, 8);
      run(0, 40);
      total++;
      if (terr[0] !== 1'b0) begin
         bad++;
         $display("FAIL limit_edge_err got=%b want=0", terr[0]);
      end
   endtask

   task automatic test_reset_mid_op();
      m_valid[0][0] = 1'b1; m_we[0][0] = 1'b0; m_addr[0][0] = 7'h12; m_wdata[0][0] = '0;
      s_ready[0] = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({s_valid[0], busy[0]} !== 2'b11) begin
         bad++;
         $display("FAIL mid_op_in_req got sv=%b busy=%b want 1 1", s_valid[0], busy[0]);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({s_valid[0], busy[0], m_ready[0][0], m_ready[0][1]} !== 4'b0000) begin
         bad++;
         $display("FAIL async_reset got sv=%b busy=%b rdy=%b%b want 0 0 00",
                  s_valid[0], busy[0], m_ready[0][0], m_ready[0][1]);
      end
      m_valid[0][0] = 1'b0;
      for (int i = 0; i < 2; i++) begin hold[i][0] = '0; hold[i][1] = '0; end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tgt_delay = 1; tgt_rdata = 32'hA5A5_0001;
      add(1'b1, 1'b0, 7'h13, 32'h0, 32'hA5A5_0001, 2, 1);
      run(0, 30);
   endtask

`ifdef DMI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      tgt_never = 1'b1; tgt_rdata = 32'h0000_0042;
      add(1'b0, 1'b0, 7'h16, 32'h0, 32'hDEAD_BEEF, 0, 8);
      run(0, 40);
      total++;
      if (terr[0] !== 1'b1) begin
         bad++;
         $display("FAIL timeout_err_set got=%b want=1", terr[0]);
      end
      tgt_delay = 1; tgt_rdata = 32'h0000_0043;
      add(1'b1, 1'b0, 7'h17, 32'h0, 32'h0000_0043, 0, 1);
      run(0, 30);
      total++;
      if (terr[0] !== 1'b1) begin
         bad++;
         $display("FAIL timeout_err_sticky got=%b want=1", terr[0]);
      end
   endtask
`endif

   task automatic test_err_flags();
      logic exp0;
`ifdef DMI_ARB_TIMEOUT_EN
      exp0 = 1'b1;
`else
      exp0 = 1'b0;
`endif
      total++;
      if ({terr[0], terr[1]} !== {exp0, 1'b0}) begin
         bad++;
         $display("FAIL err_flags got=%b%b want=%b0", terr[0], terr[1], exp0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tgt_delay = 1; tgt_never = 1'b0; tgt_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         s_ready[i] = 1'b0; s_rdata[i] = '0;
         for (int r = 0; r < 2; r++) begin
            m_valid[i][r] = 1'b0; m_we[i][r] = 1'b0; m_addr[i][r] = '0; m_wdata[i][r] = '0;
            hold[i][r] = '0;
         end
      end
      test_reset();
      test_contention();
      test_single_read();
      test_write();
      test_rr_ptr();
      test_fixed_priority();
      test_limit_edge();
      test_reset_mid_op();
`ifdef DMI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_err_flags();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
